// File: rtl/mod_74xx_sync_counter.sv
// rtl/mod_74xx_sync_counter.sv - presettable up/down modulo-N counter, 74x160/161/163 style
// Optional feature: MOD_74XX_COUNTER_SYNC_CLEAR_EN enables SCLR_n (74x163); otherwise SCLR_n is ignored (74x161).
module mod_74xx_sync_counter #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             SCLR_n,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             DN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

`ifndef MOD_74XX_COUNTER_SYNC_CLEAR_EN
    logic unused_sclr;
    assign unused_sclr = SCLR_n;
`endif

    always_comb begin
        q_d = q_q;
`ifdef MOD_74XX_COUNTER_SYNC_CLEAR_EN
        if (!SCLR_n) begin
            q_d = '0;
        end else
`endif
        if (!LOAD_n) begin
            q_d = D;
        end else if (ENP && ENT) begin
            // Out-of-range states (only reachable by load) snap to 0 when counting up.
            if (!DN) begin
                q_d = (q_q >= MAX) ? '0 : q_q + ONE;
            end else begin
                q_d = (q_q == '0) ? MAX : q_q - ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    assign RCO = ENT & ((!DN & (q_q == MAX)) | (DN & (q_q == '0)));

endmodule
